fifo_buffer: RTL and testbench
==============================

Name: fifo_buffer

Overview:
- Synchronous single-clock FIFO, 8 entries x 8 bits by default.
- Sits between a byte producer and a byte consumer in one clock domain.
- Provides registered read data, full/empty status and the raw read/write pointers for debug and monitoring.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- DEPTH, 8, number of entries; must be a power of two.
- ADDR_WIDTH, 3, log2(DEPTH); pointer width is ADDR_WIDTH+1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- write_e  input  1  write request.
- read_e  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- write_ptr  output  ADDR_WIDTH+1  write pointer: MSB is the wrap bit, lower bits are the address.
- read_ptr  output  ADDR_WIDTH+1  read pointer, same format.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - write_ptr=0, read_ptr=0, data_out=0, empty=1, full=0.
  - Memory contents are not cleared.
  - Deassertion is sampled at the next rising edge.
  - Reset asserted mid-operation discards all stored entries.
- Write accepted iff write_e=1 and full=0:
  - mem[write_ptr[ADDR_WIDTH-1:0]] <= data_in; write_ptr increments by 1.
  - A write while full is ignored: no pointer or memory change.
- Read accepted iff read_e=1 and empty=0:
  - data_out <= mem[read_ptr[ADDR_WIDTH-1:0]]; read_ptr increments by 1.
  - Latency: data appears on data_out on the clock edge that accepts the read.
  - A read while empty is ignored; data_out holds its previous value.
- data_out holds its value whenever no read is accepted.
- Simultaneous read and write are evaluated independently against pre-edge flags:
  - Both accepted when neither blocks; occupancy unchanged.
  - When empty, only the write proceeds.
  - When full, only the read proceeds; no write-through or bypass.
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH.
- Flags are combinational from the pointers:
  - empty = (write_ptr == read_ptr).
  - full = (MSBs differ) and (lower ADDR_WIDTH bits equal).
- Order is strictly FIFO across wrap-around.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined:
  - Adds outputs overflow (1) and underflow (1), both reset to 0.
  - overflow is a one-cycle registered pulse after a write_e while full.
  - underflow is a one-cycle registered pulse after a read_e while empty.
- When undefined: the ports do not exist and ignored requests are silent.

Decomposition:
- Package fifo_buffer_pkg holds:
  - Default constants: DATA_WIDTH=8, DEPTH=8, ADDR_WIDTH=3.
  - typedef ptr_t, logic [ADDR_WIDTH:0].
  - typedef data_t, logic [DATA_WIDTH-1:0].
- One sub-module, fifo_mem: register-array storage with one synchronous write port and one registered read port, no reset on the array.
- Pointer and flag logic lives in fifo_buffer.

Test Plan:
- Reset: hold reset=0 for 2 cycles with write_e=1 -> empty=1, full=0, pointers=0, data_out=0, no write performed.
- Fill: release reset, write 1, 9, 7, 3, 4, 6, 8, 10 on consecutive cycles -> full=1 after the 8th write, write_ptr=4'b1000, empty=0.
- Overflow: with the FIFO full, write_e=1 with data 99 -> full stays 1, write_ptr unchanged; with FIFO_ERR_FLAGS_EN, overflow pulses for 1 cycle.
- Drain: read_e=1, write_e=0 for 10 cycles -> data_out sequence 1, 9, 7, 3, 4, 6, 8, 10; empty=1 after the 8th read; data_out holds 10 afterwards; read_ptr=4'b1000.
- Wrap/simultaneous: from 4 entries, read_e=write_e=1 for 12 cycles -> occupancy stays 4, order preserved across wrap, both pointers wrap through 4'b1111->4'b0000.
- Mid-operation reset: assert reset=0 asynchronously (off clock edge) with 5 entries stored -> empty=1, full=0, pointers=0, data_out=0 immediately; a subsequent read_e returns nothing.

Source files
------------

// File: rtl/fifo_buffer_pkg.sv
// Shared defaults and types for the fifo_buffer slice.
package fifo_buffer_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_DEPTH      = 8;
   localparam int FIFO_ADDR_WIDTH = 3;

   typedef logic [FIFO_ADDR_WIDTH:0]   ptr_t;
   typedef logic [FIFO_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one registered read port.
// The array itself is never reset; only the read data register is.
module fifo_mem import fifo_buffer_pkg::*; #(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Read data holds unless a read is accepted this cycle.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with wrap-bit pointers and combinational full/empty.
// Define FIFO_ERR_FLAGS_EN to add registered overflow/underflow pulse outputs.
module fifo_buffer import fifo_buffer_pkg::*; #(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_e,
   input  logic                  read_e,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
`ifdef FIFO_ERR_FLAGS_EN
   output logic                  overflow,
   output logic                  underflow,
`endif
   output logic [ADDR_WIDTH:0]   write_ptr,
   output logic [ADDR_WIDTH:0]   read_ptr
);

   localparam logic [ADDR_WIDTH:0] PTR_STEP = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0] wr_ptr_q;
   logic [ADDR_WIDTH:0] wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q;
   logic [ADDR_WIDTH:0] rd_ptr_d;
   logic                wr_accept;
   logic                rd_accept;

   // Both requests are judged against the flags as they stand before the edge,
   // so a full FIFO never writes through and an empty one never bypasses.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
      wr_accept = write_e && !full;
      rd_accept = read_e && !empty;
      wr_ptr_d  = wr_accept ? (wr_ptr_q + PTR_STEP) : wr_ptr_q;
      rd_ptr_d  = rd_accept ? (rd_ptr_q + PTR_STEP) : rd_ptr_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data (data_in),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data (data_out)
   );

   assign write_ptr = wr_ptr_q;
   assign read_ptr  = rd_ptr_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic overflow_d;
   logic underflow_q;
   logic underflow_d;

   always_comb begin
      overflow_d  = write_e && full;
      underflow_d = read_e && empty;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer (default 8x8 configuration).
module tb_fifo_buffer;
   import fifo_buffer_pkg::*;

   logic  clk;
   logic  reset;
   logic  write_e;
   logic  read_e;
   data_t data_in;
   data_t data_out;
   logic  full;
   logic  empty;
   ptr_t  write_ptr;
   ptr_t  read_ptr;
`ifdef FIFO_ERR_FLAGS_EN
   logic  overflow;
   logic  underflow;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fifo_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .write_e   (write_e),
      .read_e    (read_e),
      .data_in   (data_in),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty),
`ifdef FIFO_ERR_FLAGS_EN
      .overflow  (overflow),
      .underflow (underflow),
`endif
      .write_ptr (write_ptr),
      .read_ptr  (read_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] fill_vals [8];
      logic [7:0] exp_q [$];
      logic [7:0] exp_v;
      ptr_t       exp_wp;
      ptr_t       exp_rp;

      fill_vals = '{8'd1, 8'd9, 8'd7, 8'd3, 8'd4, 8'd6, 8'd8, 8'd10};

      // Reset held with a write request pending
      reset   = 1'b0;
      write_e = 1'b1;
      read_e  = 1'b0;
      data_in = 8'd55;
      tick();
      tick();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_wptr", 32'(write_ptr), 32'd0);
      chk("rst_rptr", 32'(read_ptr), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);

      // Fill
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_in = fill_vals[i];
         write_e = 1'b1;
         tick();
         chk("fill_wptr", 32'(write_ptr), 32'(i + 1));
         chk("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
         chk("fill_empty", 32'(empty), 32'd0);
      end

      // Overflow attempt
      data_in = 8'd99;
      tick();
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_wptr", 32'(write_ptr), 32'h8);
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_pulse", 32'(overflow), 32'd1);
`endif
      write_e = 1'b0;
      tick();
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_clear", 32'(overflow), 32'd0);
`endif

      // Drain, two reads past empty
      read_e = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("drain_dout", 32'(data_out), (i < 8) ? 32'(fill_vals[i]) : 32'd10);
         chk("drain_empty", 32'(empty), (i >= 7) ? 32'd1 : 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
         chk("drain_udf", 32'(underflow), (i >= 8) ? 32'd1 : 32'd0);
`endif
      end
      chk("drain_rptr", 32'(read_ptr), 32'h8);
      read_e = 1'b0;

      // Preload 4 entries, then run simultaneous read/write across wrap
      exp_wp = 5'(8);
      exp_rp = 5'(8);
      for (int i = 0; i < 4; i++) begin
         data_in = 8'(11 + i);
         write_e = 1'b1;
         exp_q.push_back(8'(11 + i));
         exp_wp  = exp_wp + 1'b1;
         tick();
      end
      chk("pre_wptr", 32'(write_ptr), 32'hC);

      read_e = 1'b1;
      for (int i = 0; i < 12; i++) begin
         data_in = 8'(21 + i);
         exp_q.push_back(8'(21 + i));
         exp_v   = exp_q.pop_front();
         exp_wp  = exp_wp + 1'b1;
         exp_rp  = exp_rp + 1'b1;
         tick();
         chk("wrap_dout", 32'(data_out), 32'(exp_v));
         chk("wrap_wptr", 32'(write_ptr), 32'(exp_wp));
         chk("wrap_rptr", 32'(read_ptr), 32'(exp_rp));
         chk("wrap_flags", {30'd0, full, empty}, 32'd0);
      end
      chk("wrap_occ", 32'(write_ptr - read_ptr), 32'd4);

      // Fifth entry, then asynchronous reset between edges
      read_e  = 1'b0;
      data_in = 8'd33;
      tick();
      write_e = 1'b0;
      chk("mid_occ", 32'(write_ptr - read_ptr), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_wptr", 32'(write_ptr), 32'd0);
      chk("arst_rptr", 32'(read_ptr), 32'd0);
      chk("arst_dout", 32'(data_out), 32'd0);

      // Read after reset finds nothing
      reset  = 1'b1;
      read_e = 1'b1;
      tick();
      chk("post_dout", 32'(data_out), 32'd0);
      chk("post_rptr", 32'(read_ptr), 32'd0);
      chk("post_empty", 32'(empty), 32'd1);

      // Simultaneous on empty: only the write proceeds
      write_e = 1'b1;
      data_in = 8'h5A;
      tick();
      chk("se_wptr", 32'(write_ptr), 32'd1);
      chk("se_rptr", 32'(read_ptr), 32'd0);
      chk("se_dout", 32'(data_out), 32'd0);
      write_e = 1'b0;
      tick();
      chk("se_read", 32'(data_out), 32'h5A);
      chk("se_empty", 32'(empty), 32'd1);
      read_e = 1'b0;

      // Full with both requests: read proceeds, write ignored
      write_e = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_in = 8'(40 + i);
         tick();
      end
      chk("sf_full", 32'(full), 32'd1);
      read_e  = 1'b1;
      data_in = 8'd77;
      tick();
      chk("sf_dout", 32'(data_out), 32'd40);
      chk("sf_wptr", 32'(write_ptr), 32'h1 + 32'h8);
      chk("sf_full2", 32'(full), 32'd0);
      write_e = 1'b0;
      read_e  = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
